spram_clr: RTL and testbench



---
 rtl/spram_clr_pkg.sv | 10 +
 rtl/spram_lane.sv | 46 ++++
 rtl/spram_clr.sv | 118 +++++++++++
 tb/tb_spram_clr.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/spram_clr_pkg.sv
// Shared constants for the spram_clr single-port RAM with built-in clear sequencer.
package spram_clr_pkg;

  localparam logic [0:0] S_CLEAR = 1'b0;
  localparam logic [0:0] S_IDLE  = 1'b1;

  localparam int unsigned RD_FIRST   = 0;
  localparam int unsigned WR_THROUGH = 1;

endpackage

// File: rtl/spram_lane.sv
// One byte lane of the RAM: MEMSIZE x BYTEBITS array, single write enable, registered read.
module spram_lane #(
  parameter int unsigned BYTEBITS = 8,
  parameter int unsigned ADDRBITS = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDRBITS-1:0] addr,
  input  logic [BYTEBITS-1:0] wdata,
  input  logic                we,
  input  logic                re,
  input  logic                byp,
  output logic [BYTEBITS-1:0] rdata
);

  localparam int unsigned MEMSIZE = 1 << ADDRBITS;

  logic [BYTEBITS-1:0] mem_q [MEMSIZE];
  logic [BYTEBITS-1:0] rdata_d;
  logic [BYTEBITS-1:0] rdata_q;

  // byp returns the lane's incoming write data instead of the stored byte
  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      rdata_d = byp ? wdata : mem_q[addr];
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/spram_clr.sv
// Single-port RAM with byte-lane writes, 1-cycle registered read and a whole-array
// clear sequencer that runs after reset and on clr_req.
module spram_clr
  import spram_clr_pkg::*;
#(
  parameter int unsigned          DATABITS = 32,
  parameter int unsigned          BYTEBITS = 8,
  parameter int unsigned          ADDRBITS = 5,
  parameter int unsigned          RDMODE   = RD_FIRST,
  parameter logic [DATABITS-1:0]  CLRVAL   = '0
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [ADDRBITS-1:0]            addr,
  input  logic [DATABITS-1:0]            data_in,
  input  logic [DATABITS/BYTEBITS-1:0]   we,
  input  logic                           re,
  output logic [DATABITS-1:0]            data_out,
  output logic                           rd_valid,
  input  logic                           clr_req,
  output logic                           ready
);

  localparam int unsigned NLANES   = DATABITS / BYTEBITS;
  localparam int unsigned MEMSIZE  = 1 << ADDRBITS;
  localparam int unsigned PTRW     = ADDRBITS + 1;
  localparam logic [PTRW-1:0] PTR_LAST = PTRW'(MEMSIZE - 1);

  logic [0:0]               state_d,    state_q;
  logic [PTRW-1:0]          ptr_d,      ptr_q;
  logic                     ready_d,    ready_q;
  logic                     rd_valid_d, rd_valid_q;

  logic [NLANES-1:0]        lane_we_c;
  logic [NLANES-1:0]        byp_c;
  logic [ADDRBITS-1:0]      lane_addr_c;
  logic [DATABITS-1:0]      lane_wdata_c;
  logic                     lane_re_c;
  logic [NLANES-1:0][BYTEBITS-1:0] lane_rd;

  // Next state plus write mux: clear sequencer owns the array until the last word is written
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    ready_d      = ready_q;
    rd_valid_d   = 1'b0;
    lane_we_c    = '0;
    lane_re_c    = 1'b0;
    lane_addr_c  = addr;
    lane_wdata_c = data_in;
    byp_c        = '0;
    case (state_q)
      S_CLEAR: begin
        lane_we_c    = '1;
        lane_addr_c  = ptr_q[ADDRBITS-1:0];
        lane_wdata_c = CLRVAL;
        ptr_d        = ptr_q + PTRW'(1);
        if (ptr_q == PTR_LAST) begin
          state_d = S_IDLE;
          ready_d = 1'b1;
        end
      end
      S_IDLE: begin
        lane_we_c  = we;
        lane_re_c  = re;
        rd_valid_d = re;
        if (RDMODE == WR_THROUGH) begin
          byp_c = we;
        end
        if (clr_req) begin
          state_d = S_CLEAR;
          ptr_d   = '0;
          ready_d = 1'b0;
        end
      end
      default: begin
        state_d = S_CLEAR;
        ptr_d   = '0;
        ready_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_CLEAR;
      ptr_q      <= '0;
      ready_q    <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      ready_q    <= ready_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  for (genvar i = 0; i < int'(NLANES); i++) begin : g_lane
    spram_lane #(
      .BYTEBITS (BYTEBITS),
      .ADDRBITS (ADDRBITS)
    ) u_lane (
      .clk   (clk),
      .reset (reset),
      .addr  (lane_addr_c),
      .wdata (lane_wdata_c[i*BYTEBITS +: BYTEBITS]),
      .we    (lane_we_c[i]),
      .re    (lane_re_c),
      .byp   (byp_c[i]),
      .rdata (lane_rd[i])
    );
  end

  assign data_out = lane_rd;
  assign rd_valid = rd_valid_q;
  assign ready    = ready_q;

endmodule

// File: tb/tb_spram_clr.sv
// Randomised bench for spram_clr: three instances (read-first, write-through, small array
// with non-zero clear value) checked every cycle against an array-level reference model.
module tb_spram_clr;

  logic        clk;
  logic        reset;
  logic [4:0]  addr;
  logic [31:0] data_in;
  logic [3:0]  we;
  logic        re;
  logic        clr_req;

  logic [2:0]  rdy;
  logic [2:0]  rv;
  logic [31:0] dout [3];

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  spram_clr #(.ADDRBITS(5), .RDMODE(0), .CLRVAL(32'h0)) u_dut0 (
    .clk(clk), .reset(reset), .addr(addr), .data_in(data_in), .we(we), .re(re),
    .data_out(dout[0]), .rd_valid(rv[0]), .clr_req(clr_req), .ready(rdy[0]));

  spram_clr #(.ADDRBITS(5), .RDMODE(1), .CLRVAL(32'h0)) u_dut1 (
    .clk(clk), .reset(reset), .addr(addr), .data_in(data_in), .we(we), .re(re),
    .data_out(dout[1]), .rd_valid(rv[1]), .clr_req(clr_req), .ready(rdy[1]));

  spram_clr #(.ADDRBITS(3), .RDMODE(0), .CLRVAL(32'hA5A5A5A5)) u_dut2 (
    .clk(clk), .reset(reset), .addr(addr[2:0]), .data_in(data_in), .we(we), .re(re),
    .data_out(dout[2]), .rd_valid(rv[2]), .clr_req(clr_req), .ready(rdy[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: array-level view; a clear becomes visible all at once when it completes
  int unsigned msize [3] = '{32, 32, 8};
  logic [31:0] mclr  [3] = '{32'h0, 32'h0, 32'hA5A5A5A5};
  bit          mwt   [3] = '{1'b0, 1'b1, 1'b0};
  logic [31:0] mmem  [3][32];
  int          left  [3];
  bit          e_rdy [3];
  bit          e_rv  [3];
  logic [31:0] e_do  [3];
  int          m_a;
  logic [31:0] m_old;
  logic [31:0] m_new;

  initial forever begin
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      if (reset) begin
        left[k]  = int'(msize[k]);
        e_rdy[k] = 1'b0;
        e_rv[k]  = 1'b0;
        e_do[k]  = 32'h0;
      end else if (!e_rdy[k]) begin
        e_rv[k] = 1'b0;
        left[k] = left[k] - 1;
        if (left[k] == 0) begin
          for (int j = 0; j < int'(msize[k]); j++) mmem[k][j] = mclr[k];
          e_rdy[k] = 1'b1;
        end
      end else begin
        m_a   = int'(addr) % int'(msize[k]);
        m_old = mmem[k][m_a];
        m_new = m_old;
        for (int l = 0; l < 4; l++) if (we[l]) m_new[l*8 +: 8] = data_in[l*8 +: 8];
        if (re) e_do[k] = mwt[k] ? m_new : m_old;
        e_rv[k] = re;
        mmem[k][m_a] = m_new;
        if (clr_req) begin
          e_rdy[k] = 1'b0;
          left[k]  = int'(msize[k]);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("ready%0d", k), 32'(rdy[k]), 32'(e_rdy[k]));
        chk($sformatf("rd_valid%0d", k), 32'(rv[k]), 32'(e_rv[k]));
        chk($sformatf("data_out%0d", k), dout[k], e_do[k]);
      end
    end
  end

  task automatic op(input logic [4:0] a, input logic [31:0] d, input logic [3:0] w,
                    input logic r, input logic c);
    addr = a; data_in = d; we = w; re = r; clr_req = c;
    @(negedge clk);
    addr = '0; data_in = '0; we = '0; re = 1'b0; clr_req = 1'b0;
  endtask

  task automatic count_clear(output int c0, output int c2);
    c0 = 0;
    c2 = 0;
    for (int i = 0; i < 40; i++) begin
      if (!rdy[0]) c0++;
      if (!rdy[2]) c2++;
      @(negedge clk);
    end
  endtask

  int cnt0, cnt2;

  initial begin
    reset = 1'b1; addr = '0; data_in = '0; we = '0; re = 1'b0; clr_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    chk("rst_ready", 32'(rdy[0]), 32'h0);
    chk("rst_rd_valid", 32'(rv[0]), 32'h0);
    chk("rst_data_out", dout[0], 32'h0);

    // Clear after reset: 32 cycles at default size, 8 at ADDRBITS=3
    reset = 1'b0;
    count_clear(cnt0, cnt2);
    chk("clear_len_32", 32'(cnt0), 32'd32);
    chk("clear_len_8", 32'(cnt2), 32'd8);

    op(5'd2, 32'h0, 4'h0, 1'b1, 1'b0);
    chk("clr_word_0", dout[0], 32'h0);
    chk("clr_word_a5", dout[2], 32'hA5A5A5A5);
    for (int a = 0; a < 32; a++) op(5'(a), 32'h0, 4'h0, 1'b1, 1'b0);
    op(5'd0, 32'h0, 4'h0, 1'b0, 1'b0);
    chk("idle_no_rv_small", 32'(rv[2]), 32'h0);

    // Byte-lane merge
    op(5'd5, 32'hDEADBEEF, 4'b1111, 1'b0, 1'b0);
    op(5'd5, 32'h11223344, 4'b0101, 1'b0, 1'b0);
    op(5'd5, 32'h0, 4'b0000, 1'b1, 1'b0);
    chk("merge_data", dout[0], 32'hDE22BE44);
    chk("merge_rv", 32'(rv[0]), 32'h1);
    op(5'd0, 32'h0, 4'b0000, 1'b0, 1'b0);
    chk("merge_rv_pulse", 32'(rv[0]), 32'h0);
    chk("merge_hold", dout[0], 32'hDE22BE44);

    // Same-cycle read and write
    op(5'd3, 32'h01020304, 4'b1111, 1'b0, 1'b0);
    op(5'd3, 32'hCAFEF00D, 4'b1111, 1'b1, 1'b0);
    chk("rw_read_first", dout[0], 32'h01020304);
    chk("rw_write_through", dout[1], 32'hCAFEF00D);
    op(5'd3, 32'h0, 4'b0000, 1'b1, 1'b0);
    chk("rw_after_rf", dout[0], 32'hCAFEF00D);
    chk("rw_after_wt", dout[1], 32'hCAFEF00D);

    // Random traffic with occasional clears
    for (int i = 0; i < 400; i++)
      op(5'($urandom), $urandom, 4'($urandom), 1'($urandom_range(0, 1)),
         ($urandom_range(0, 49) == 0));
    for (int i = 0; i < 40 && !rdy[0]; i++) op(5'd0, 32'h0, 4'h0, 1'b0, 1'b0);
    chk("wait_ready", 32'(rdy[0]), 32'h1);

    // Fill, then clear with accesses attempted during the clear
    for (int a = 0; a < 32; a++) op(5'(a), $urandom, 4'b1111, 1'b0, 1'b0);
    op(5'd9, 32'h55555555, 4'b1111, 1'b1, 1'b1);
    cnt0 = rdy[0] ? 0 : 1;
    cnt2 = rdy[2] ? 0 : 1;
    op(5'd7, 32'h12345678, 4'b1111, 1'b1, 1'b0);
    chk("clear_drop_rv", 32'(rv[0]), 32'h0);
    if (!rdy[0]) cnt0++;
    if (!rdy[2]) cnt2++;
    for (int i = 0; i < 38; i++) begin
      op(5'd0, 32'h0, 4'h0, 1'b0, 1'b0);
      if (!rdy[0]) cnt0++;
      if (!rdy[2]) cnt2++;
    end
    chk("reclear_len_32", 32'(cnt0), 32'd32);
    chk("reclear_len_8", 32'(cnt2), 32'd8);
    op(5'd7, 32'h0, 4'h0, 1'b1, 1'b0);
    chk("clear_drop_write", dout[0], 32'h0);
    for (int a = 0; a < 32; a++) op(5'(a), 32'h0, 4'h0, 1'b1, 1'b0);

    // Reset part-way through a clear restarts it from word 0
    op(5'd0, 32'h0, 4'h0, 1'b0, 1'b1);
    for (int i = 0; i < 9; i++) op(5'd0, 32'h0, 4'h0, 1'b0, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    count_clear(cnt0, cnt2);
    chk("rst_mid_clear_32", 32'(cnt0), 32'd32);
    chk("rst_mid_clear_8", 32'(cnt2), 32'd8);
    for (int a = 0; a < 32; a++) op(5'(a), 32'h0, 4'h0, 1'b1, 1'b0);
    op(5'd0, 32'h0, 4'h0, 1'b0, 1'b0);

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
